// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the rv64IM MEM stage.
// Covers the FSM state codes, funct3 size encodings and the default access timeout.
package mem_stage_pkg;

    localparam int XLEN          = 64;
    localparam int TIMEOUT_DEF   = 255;
    localparam int TIMEOUT_W_DEF = 8;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    // funct3[1:0] gives log2 of the access size; funct3[2] marks a zero-extending load.
    localparam logic [1:0] F3_B = 2'd0;
    localparam logic [1:0] F3_H = 2'd1;
    localparam logic [1:0] F3_W = 2'd2;
    localparam logic [1:0] F3_D = 2'd3;
    localparam int         F3_UNSIGNED_BIT = 2;

    function automatic logic [3:0] access_size(input logic [1:0] log2_size);
        return 4'd1 << log2_size;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and the memory.
// The request side is held stable until the memory acknowledges it.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [7:0]      dmem_wmask_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_ack_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wmask_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wmask_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i
    );

endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane steering for both directions: store mask/data placement, the misalignment test,
// and extraction plus sign/zero extension of load data.
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [2:0]      offset_i,
    input  logic [XLEN-1:0] sdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [7:0]      wmask_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] load_o
);

    logic [3:0]      w_size;
    logic [7:0]      w_base_mask;
    logic [XLEN-1:0] w_shifted;
    logic            w_unsigned;

    assign w_size     = access_size(funct3_i[1:0]);
    assign misalign_o = ({1'b0, offset_i} + w_size) > 4'd8;
    assign wdata_o    = sdata_i << {offset_i, 3'b000};
    assign w_shifted  = rdata_i >> {offset_i, 3'b000};
    assign w_unsigned = funct3_i[F3_UNSIGNED_BIT];
    assign wmask_o    = w_base_mask << offset_i;

    always_comb begin
        // NOTE: every output of this block is given a default first so no path infers a latch.
        w_base_mask = 8'hFF;
        load_o      = w_shifted;
        case (funct3_i[1:0])
            F3_B: begin
                w_base_mask = 8'h01;
                load_o      = {{56{~w_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_H: begin
                w_base_mask = 8'h03;
                load_o      = {{48{~w_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_W: begin
                w_base_mask = 8'h0F;
                load_o      = {{32{~w_unsigned & w_shifted[31]}}, w_shifted[31:0]};
            end
            F3_D:    ;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the rv64IM pipeline: drives the data-memory port, stalls upstream while an
// access is outstanding, and holds the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] aluout_i,
    input  logic            load_i,
    input  logic            store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] sdata_i,
    input  logic            wen_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            exit_i,
    mem_stage_if.master     dmem,
    output logic            stall_req_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            wb_wen_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [XLEN-1:0] wb_pc_o,
    output logic            wb_exit_o
);

    mem_state_e           r_state, w_next_state;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [4:0]           r_rd;
    logic [2:0]           r_funct3, r_off;
    logic                 r_wen, r_load, r_exit;
    logic [XLEN-1:0]      r_pc;

    logic            w_busy, w_mem_op, w_issue, w_ack, w_timeout, w_misalign;
    logic [2:0]      w_f3, w_off;
    logic [7:0]      w_wmask;
    logic [XLEN-1:0] w_wdata, w_load_val;

    assign w_busy    = (r_state == MEM_BUSY);
    assign w_mem_op  = load_i | store_i;
    // In BUSY the upstream inputs are frozen, so load extraction uses the held access shape.
    assign w_f3      = w_busy ? r_funct3 : funct3_i;
    assign w_off     = w_busy ? r_off    : aluout_i[2:0];
    assign w_issue   = ~w_busy & w_mem_op & ~w_misalign;
    assign w_ack     = w_busy & dmem.dmem_ack_i;
    assign w_timeout = w_busy & ~dmem.dmem_ack_i & (r_cnt == TIMEOUT_W'(TIMEOUT - 1));

    mem_stage_align u_align (
        .funct3_i   (w_f3),
        .offset_i   (w_off),
        .sdata_i    (sdata_i),
        .rdata_i    (dmem.dmem_rdata_i),
        .wmask_o    (w_wmask),
        .wdata_o    (w_wdata),
        .misalign_o (w_misalign),
        .load_o     (w_load_val)
    );

    always_comb begin
        w_next_state = r_state;
        stall_req_o  = 1'b0;
        case (r_state)
            MEM_IDLE: if (w_issue) begin
                stall_req_o  = 1'b1;
                w_next_state = MEM_BUSY;
            end
            MEM_BUSY: if (w_ack || w_timeout) w_next_state = MEM_IDLE;
                      else                    stall_req_o  = 1'b1;
            default:  w_next_state = MEM_IDLE;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= MEM_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dmem.dmem_req_o   <= 1'b0;
            dmem.dmem_we_o    <= 1'b0;
            dmem.dmem_addr_o  <= '0;
            dmem.dmem_wmask_o <= '0;
            dmem.dmem_wdata_o <= '0;
            r_cnt <= '0;  r_rd <= '0;   r_funct3 <= '0; r_off <= '0;
            r_wen <= 1'b0; r_load <= 1'b0; r_exit <= 1'b0; r_pc <= '0;
            misalign_o <= 1'b0; bus_err_o <= 1'b0;
            wb_wen_o <= 1'b0; wb_rd_o <= '0; wb_data_o <= '0; wb_pc_o <= '0; wb_exit_o <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            if (!w_busy && w_issue) begin
                dmem.dmem_req_o   <= 1'b1;
                dmem.dmem_we_o    <= store_i;
                dmem.dmem_addr_o  <= {aluout_i[XLEN-1:3], 3'b000};
                dmem.dmem_wmask_o <= store_i ? w_wmask : 8'h00;
                dmem.dmem_wdata_o <= w_wdata;
                r_cnt <= '0;      r_rd <= rd_i;      r_funct3 <= funct3_i;
                r_off <= aluout_i[2:0]; r_wen <= wen_i; r_load <= load_i;
                r_exit <= exit_i; r_pc <= pc_i;
                wb_wen_o <= 1'b0; wb_rd_o <= '0; wb_data_o <= '0; wb_pc_o <= '0; wb_exit_o <= 1'b0;
            end else if (!w_busy) begin
                misalign_o <= w_mem_op & w_misalign;
                wb_wen_o   <= wen_i & ~w_mem_op;
                wb_rd_o    <= rd_i;
                wb_data_o  <= aluout_i;
                wb_pc_o    <= pc_i;
                wb_exit_o  <= exit_i;
            end else if (w_ack || w_timeout) begin
                dmem.dmem_req_o <= 1'b0;
                bus_err_o <= w_timeout;
                wb_wen_o  <= w_ack & r_load & r_wen;
                wb_rd_o   <= r_rd;
                wb_data_o <= (w_ack && r_load) ? w_load_val : '0;
                wb_pc_o   <= r_pc;
                wb_exit_o <= r_exit;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                wb_wen_o <= 1'b0; wb_rd_o <= '0; wb_data_o <= '0; wb_pc_o <= '0; wb_exit_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver plays the frozen-on-stall EX stage, a responder
// plays the data memory, and two monitors compare the MEM/WB register and memory requests.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] aluout_i = '0, sdata_i = '0, pc_i = '0;
    logic        load_i = 1'b0, store_i = 1'b0, wen_i = 1'b0, exit_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  rd_i = '0;
    logic        stall_req_o, misalign_o, bus_err_o, wb_wen_o, wb_exit_o;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o, wb_pc_o;

    mem_stage_if dmem ();

    mem_stage dut (
        .clock(clock), .reset(reset),
        .aluout_i(aluout_i), .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
        .sdata_i(sdata_i), .wen_i(wen_i), .rd_i(rd_i), .pc_i(pc_i), .exit_i(exit_i),
        .dmem(dmem),
        .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .wb_wen_o(wb_wen_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .wb_pc_o(wb_pc_o), .wb_exit_o(wb_exit_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        chk_data;
        logic [63:0] pc;
        logic        ex;
        logic        mis;
        logic        berr;
    } wb_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        int          busy;
    } req_exp_t;

    wb_exp_t     wb_q[$];
    req_exp_t    req_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_delay = 0;
    logic [63:0] mem_rdata = '0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Reference model: byte-level view of the access, independent of any shifter structure.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] model_mask(input int off, input int n);
        logic [7:0] m = '0;
        for (int i = 0; i < n; i++) m[off + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] sd, input int off);
        logic [63:0] w = '0;
        for (int i = 0; i + off < 8; i++) w[8*(off + i) +: 8] = sd[8*i +: 8];
        return w;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                               input logic [2:0] f3);
        int          n = size_of(f3);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off + i) +: 8];
        if (!f3[2] && v[8*n - 1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Present one EX op, record what must come out, and hold the op until the stage accepts it.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] alu, input logic [63:0] sd, input logic w,
                         input logic [4:0] rd, input logic [63:0] pc, input logic ex,
                         input int delay, input logic [63:0] rdata);
        wb_exp_t  e;
        req_exp_t r;
        int       off, n, guard;
        bit       mis, access;
        off    = int'(alu[2:0]);
        n      = size_of(f3);
        mis    = (ld || st) && (off + n > 8);
        access = (ld || st) && !mis;
        load_i = ld; store_i = st; funct3_i = f3; aluout_i = alu; sdata_i = sd;
        wen_i = w; rd_i = rd; pc_i = pc; exit_i = ex;
        ack_delay = delay; mem_rdata = rdata;

        e.rd = rd; e.pc = pc; e.ex = ex; e.mis = mis; e.berr = 1'b0;
        e.wen = 1'b0; e.data = '0; e.chk_data = 1'b0;
        if (!(ld || st)) begin
            e.wen = w; e.data = alu; e.chk_data = 1'b1;
        end else if (access) begin
            r.addr  = {alu[63:3], 3'b000};
            r.we    = st;
            r.wmask = model_mask(off, n);
            r.wdata = model_wdata(sd, off);
            r.busy  = (delay == 0) ? TIMEOUT_DEF : delay;
            req_q.push_back(r);
            if (delay == 0) e.berr = 1'b1;
            else if (ld) begin
                e.wen = w; e.data = model_load(rdata, off, f3); e.chk_data = 1'b1;
            end
        end
        wb_q.push_back(e);

        @(negedge clock);
        check("stall_on_issue", stall_req_o, access);
        guard = 0;
        while (stall_req_o && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (stall_req_o) begin
            n_tests++; n_fail++;
            $display("FAIL stall_timeout: stall still %b after %0d cycles, required 0", stall_req_o, guard);
            finish_run();
        end
        @(posedge clock); #1;
    endtask

    // The op on the inputs retires at any edge preceded by a cycle with stall low.
    initial begin : wb_mon
        bit      pend;
        wb_exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clock);
            if (!mon_en) pend = 1'b0;
            else begin
                if (pend) begin
                    if (wb_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL wb_unexpected: retire with pc %h, required none", wb_pc_o);
                    end else begin
                        e = wb_q.pop_front();
                        check("wb_wen", wb_wen_o, e.wen);
                        check("wb_rd", wb_rd_o, e.rd);
                        check("wb_pc", wb_pc_o, e.pc);
                        check("wb_exit", wb_exit_o, e.ex);
                        check("misalign_pulse", misalign_o, e.mis);
                        check("bus_err_pulse", bus_err_o, e.berr);
                        if (e.chk_data) check("wb_data", wb_data_o, e.data);
                    end
                end
                pend = !stall_req_o;
            end
        end
    end

    initial begin : req_mon
        bit          prev, have, moved;
        int          cnt;
        req_exp_t    r;
        logic [63:0] a0, d0;
        logic [7:0]  m0;
        logic        w0;
        prev = 1'b0; have = 1'b0; moved = 1'b0; cnt = 0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                prev = 1'b0; have = 1'b0; cnt = 0;
            end else begin
                if (dmem.dmem_req_o && !prev) begin
                    cnt = 0; moved = 1'b0; have = 1'b0;
                    a0 = dmem.dmem_addr_o; d0 = dmem.dmem_wdata_o;
                    m0 = dmem.dmem_wmask_o; w0 = dmem.dmem_we_o;
                    if (req_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL req_unexpected: request to %h, required none", a0);
                    end else begin
                        r = req_q.pop_front();
                        have = 1'b1;
                        check("dmem_addr", a0, r.addr);
                        check("dmem_we", w0, r.we);
                        if (r.we) begin
                            check("dmem_wmask", m0, r.wmask);
                            check("dmem_wdata", d0, r.wdata);
                        end
                    end
                end
                if (dmem.dmem_req_o) begin
                    cnt++;
                    if (dmem.dmem_addr_o !== a0 || dmem.dmem_wdata_o !== d0 ||
                        dmem.dmem_wmask_o !== m0 || dmem.dmem_we_o !== w0) moved = 1'b1;
                end else if (prev && have) begin
                    check("req_busy_cycles", cnt, r.busy);
                    check("req_stable", moved, 1'b0);
                    have = 1'b0;
                end
                prev = dmem.dmem_req_o;
            end
        end
    end

    // Memory model: acknowledge in the ack_delay-th cycle of the request; 0 means never.
    initial begin : responder
        int busy_n;
        busy_n = 0;
        dmem.dmem_ack_i   = 1'b0;
        dmem.dmem_rdata_i = '0;
        forever begin
            @(posedge clock); #1;
            if (dmem.dmem_req_o) busy_n++;
            else                 busy_n = 0;
            dmem.dmem_ack_i   = (ack_delay != 0) && (busy_n == ack_delay);
            dmem.dmem_rdata_i = dmem.dmem_ack_i ? mem_rdata : 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    initial begin : stimulus
        int          kind, n, dly;
        logic [2:0]  f3;
        logic [63:0] a;

        repeat (3) @(posedge clock);
        #1;
        check("rst_req", dmem.dmem_req_o, 1'b0);
        check("rst_we", dmem.dmem_we_o, 1'b0);
        check("rst_wb_wen", wb_wen_o, 1'b0);
        check("rst_wb_rd", wb_rd_o, 5'd0);
        check("rst_wb_data", wb_data_o, 64'd0);
        check("rst_wb_pc", wb_pc_o, 64'd0);
        check("rst_wb_exit", wb_exit_o, 1'b0);
        check("rst_misalign", misalign_o, 1'b0);
        check("rst_bus_err", bus_err_o, 1'b0);
        check("rst_stall", stall_req_o, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        mon_en = 1'b1;

        // Plain ALU result, signed and unsigned byte loads, a high-lane halfword store,
        // a misaligned word load, then a slow doubleword load followed directly by an ALU op.
        issue(1'b0, 1'b0, 3'b000, 64'h1234, '0, 1'b1, 5'd5, 64'h100, 1'b0, 0, '0);
        issue(1'b1, 1'b0, 3'b000, 64'h1003, '0, 1'b1, 5'd7, 64'h104, 1'b0, 1, 64'h0000_0000_8000_0000);
        issue(1'b1, 1'b0, 3'b100, 64'h1003, '0, 1'b1, 5'd8, 64'h108, 1'b0, 1, 64'h0000_0000_8000_0000);
        issue(1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 1'b0, 5'd0, 64'h10C, 1'b0, 2, '0);
        issue(1'b1, 1'b0, 3'b010, 64'h3006, '0, 1'b1, 5'd9, 64'h110, 1'b0, 1, '0);
        issue(1'b1, 1'b0, 3'b011, 64'h3008, '0, 1'b1, 5'd10, 64'h114, 1'b0, 3, 64'h8877_6655_4433_2211);
        issue(1'b0, 1'b0, 3'b000, 64'h55AA, '0, 1'b1, 5'd11, 64'h118, 1'b1, 0, '0);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            f3   = (kind == 1) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            n    = size_of(f3);
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~(3'(n - 1));
            dly  = $urandom_range(1, 4);
            issue(kind == 1, kind == 2, f3, a, {$urandom, $urandom}, 1'($urandom),
                  5'($urandom), {$urandom, $urandom}, $urandom_range(0, 9) == 0,
                  dly, {$urandom, $urandom});
        end

        // Memory never answers: the access must be abandoned after the timeout.
        issue(1'b1, 1'b0, 3'b011, 64'h4000, '0, 1'b1, 5'd12, 64'h200, 1'b1, 0, '0);
        @(negedge clock); #1;
        check("wb_queue_drained", wb_q.size(), 0);
        check("req_queue_drained", req_q.size(), 0);
        mon_en = 1'b0;

        // Asynchronous reset in the third cycle of an outstanding access.
        load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b011; aluout_i = 64'h5000;
        wen_i = 1'b1; rd_i = 5'd13; pc_i = 64'h300; exit_i = 1'b0; ack_delay = 0;
        repeat (3) @(posedge clock);
        #2;
        check("midreset_req_before", dmem.dmem_req_o, 1'b1);
        reset = 1'b0;
        #1;
        check("midreset_req", dmem.dmem_req_o, 1'b0);
        check("midreset_wb_wen", wb_wen_o, 1'b0);
        check("midreset_wb_rd", wb_rd_o, 5'd0);
        check("midreset_wb_data", wb_data_o, 64'd0);
        check("midreset_wb_pc", wb_pc_o, 64'd0);
        load_i = 1'b0; wen_i = 1'b0; aluout_i = '0;
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        mon_en = 1'b1;
        issue(1'b0, 1'b0, 3'b000, 64'hCAFE, '0, 1'b1, 5'd14, 64'h304, 1'b0, 0, '0);
        @(negedge clock); #1;
        check("post_reset_drained", wb_q.size(), 0);
        mon_en = 1'b0;

        finish_run();
    end

endmodule
